// File: rtl/tl_pkg.sv
// Shared definitions for the left-turn traffic light controller and its sensor front end.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package tl_pkg;

  localparam int NUM_CH = 4;
  localparam int CH_A   = 0;
  localparam int CH_AL  = 1;
  localparam int CH_B   = 2;
  localparam int CH_BL  = 3;

  localparam int DEB_CYCLES_DEF  = 4;
  localparam int HOLD_CYCLES_DEF = 8;
  localparam int CNT_W_DEF       = 8;

  // Light codes driven by tl_cntr_w_left, kept here so producer and consumer agree.
  typedef enum logic [1:0] {
    LIGHT_GREEN  = 2'b00,
    LIGHT_YELLOW = 2'b01,
    LIGHT_RED    = 2'b10,
    LIGHT_LEFT   = 2'b11
  } light_t;

endpackage

// File: rtl/tl_sensor_ch.sv
// One detector channel: 2-flop sync, debounce, optional presence-hold (TL_SENSOR_STRETCH_EN).
// Latency: 2+DEB_CYCLES edges raw->deb; output decoded from registers only.
// Backpressure: none, free-running sampler.
module tl_sensor_ch #(
  parameter int DEB_CYCLES  = 4,
  parameter int HOLD_CYCLES = 8,
  parameter int CNT_W       = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic t
);

  localparam int CNT_MAX = (1 << CNT_W) - 1;
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);

  generate
    if (DEB_CYCLES < 1 || DEB_CYCLES > CNT_MAX) begin : g_bad_deb
      $error("tl_sensor_ch: DEB_CYCLES out of range 1..2^CNT_W-1");
    end
    if (HOLD_CYCLES < 0 || HOLD_CYCLES > CNT_MAX) begin : g_bad_hold
      $error("tl_sensor_ch: HOLD_CYCLES out of range 0..2^CNT_W-1");
    end
  endgenerate

  logic             s1_q, s1_d;
  logic             s2_q, s2_d;
  logic             deb_q, deb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // cnt only runs while s2 disagrees with deb, so any return to deb restarts the run.
  always_comb begin
    s1_d  = raw;
    s2_d  = s1_q;
    deb_d = deb_q;
    cnt_d = '0;
    if (s2_q != deb_q) begin
      if (cnt_q == DEB_LAST) begin
        deb_d = s2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q  <= 1'b0;
      s2_q  <= 1'b0;
      deb_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      s1_q  <= s1_d;
      s2_q  <= s2_d;
      deb_q <= deb_d;
      cnt_q <= cnt_d;
    end
  end

`ifdef TL_SENSOR_STRETCH_EN
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES);

  logic [CNT_W-1:0] hold_q, hold_d;

  always_comb begin
    hold_d = hold_q;
    if (deb_q) begin
      hold_d = HOLD_LOAD;
    end else if (hold_q != '0) begin
      hold_d = hold_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_q <= '0;
    end else begin
      hold_q <= hold_d;
    end
  end

  assign t = deb_q | (hold_q != '0);
`else
  assign t = deb_q;
`endif

endmodule

// File: rtl/tl_sensor_cond.sv
// Four independent detector conditioning channels feeding tl_cntr_w_left; stretch via TL_SENSOR_STRETCH_EN.
// Latency: 2+DEB_CYCLES edges raw->T on a clean change; T held HOLD_CYCLES edges after release.
// Backpressure: none, outputs are level presence flags.
module tl_sensor_cond
  import tl_pkg::*;
#(
  parameter int DEB_CYCLES  = DEB_CYCLES_DEF,
  parameter int HOLD_CYCLES = HOLD_CYCLES_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw_a,
  input  logic raw_al,
  input  logic raw_b,
  input  logic raw_bl,
  output logic Ta,
  output logic Tal,
  output logic Tb,
  output logic Tbl
);

  logic [NUM_CH-1:0] raw_vec;
  logic [NUM_CH-1:0] t_vec;

  assign raw_vec[CH_A]  = raw_a;
  assign raw_vec[CH_AL] = raw_al;
  assign raw_vec[CH_B]  = raw_b;
  assign raw_vec[CH_BL] = raw_bl;

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    tl_sensor_ch #(
      .DEB_CYCLES (DEB_CYCLES),
      .HOLD_CYCLES(HOLD_CYCLES),
      .CNT_W      (CNT_W)
    ) u_ch (
      .clk    (clk),
      .reset_n(reset_n),
      .raw    (raw_vec[ch]),
      .t      (t_vec[ch])
    );
  end

  assign Ta  = t_vec[CH_A];
  assign Tal = t_vec[CH_AL];
  assign Tb  = t_vec[CH_B];
  assign Tbl = t_vec[CH_BL];

endmodule
